// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer for two masters (CPU port A,
// secondary port B) sharing the data-memory / memory-mapped I/O port.
// One transaction in flight at a time. Reads return after MEM_RD_LAT cycles.
module dmem_arbiter #(
   parameter int unsigned DBITS      = 32,
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   // port A (CPU load/store)
   input  logic             a_req,
   input  logic             a_we,
   input  logic [DBITS-1:0] a_addr,
   input  logic [DBITS-1:0] a_wdata,
   output logic             a_gnt,
   output logic             a_done,
   output logic [DBITS-1:0] a_rdata,
   // port B (debug loader / DMA)
   input  logic             b_req,
   input  logic             b_we,
   input  logic [DBITS-1:0] b_addr,
   input  logic [DBITS-1:0] b_wdata,
   output logic             b_gnt,
   output logic             b_done,
   output logic [DBITS-1:0] b_rdata,
   // memory side
   output logic             mem_we,
   output logic [DBITS-1:0] mem_addr,
   output logic [DBITS-1:0] mem_wdata,
   input  logic [DBITS-1:0] mem_rdata,
   // status
   output logic             busy,
   output logic             owner
);

   localparam int unsigned CNT_W = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RWAIT = 2'd2;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   logic [1:0]       state_q,     state_d;
   logic             we_q,        we_d;
   logic             last_q,      last_d;
   logic             owner_q,     owner_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             mem_we_q,    mem_we_d;
   logic [DBITS-1:0] mem_addr_q,  mem_addr_d;
   logic [DBITS-1:0] mem_wdata_q, mem_wdata_d;
   logic             a_done_q,    a_done_d;
   logic             b_done_q,    b_done_d;
   logic [DBITS-1:0] a_rdata_q,   a_rdata_d;
   logic [DBITS-1:0] b_rdata_q,   b_rdata_d;

   logic             sel_b_c;
   logic             a_gnt_c;
   logic             b_gnt_c;

   // State and output registers; synchronous reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         last_q      <= PORT_B;
         owner_q     <= PORT_A;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         a_done_q    <= 1'b0;
         b_done_q    <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         a_done_q    <= a_done_d;
         b_done_q    <= b_done_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   // Arbitration, sequencing and next values of the registered outputs.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      last_d      = last_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      a_done_d    = 1'b0;
      b_done_d    = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      sel_b_c     = 1'b0;
      a_gnt_c     = 1'b0;
      b_gnt_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (a_req || b_req) begin
               // B wins only when A is absent or A was served last.
               sel_b_c     = b_req && (!a_req || (last_q == PORT_A));
               a_gnt_c     = !sel_b_c;
               b_gnt_c     = sel_b_c;
               owner_d     = sel_b_c;
               last_d      = sel_b_c;
               we_d        = sel_b_c ? b_we    : a_we;
               mem_we_d    = sel_b_c ? b_we    : a_we;
               mem_addr_d  = sel_b_c ? b_addr  : a_addr;
               mem_wdata_d = sel_b_c ? b_wdata : a_wdata;
               state_d     = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (we_q) begin
               a_done_d = (owner_q == PORT_A);
               b_done_d = (owner_q == PORT_B);
               state_d  = ST_IDLE;
            end else begin
               cnt_d   = CNT_W'(MEM_RD_LAT);
               state_d = ST_RWAIT;
            end
         end

         ST_RWAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               if (owner_q == PORT_A) begin
                  a_rdata_d = mem_rdata;
                  a_done_d  = 1'b1;
               end else begin
                  b_rdata_d = mem_rdata;
                  b_done_d  = 1'b1;
               end
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grants are combinational and suppressed while reset is asserted.
   assign a_gnt     = a_gnt_c & ~reset;
   assign b_gnt     = b_gnt_c & ~reset;
   assign a_done    = a_done_q;
   assign b_done    = b_done_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter (instance u1 with
// MEM_RD_LAT=1, instance u3 with MEM_RD_LAT=3).
module tb_dmem_arbiter;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          a_req, a_we, a_gnt, a_done;
   logic [DW-1:0] a_addr, a_wdata, a_rdata;
   logic          b_req, b_we, b_gnt, b_done;
   logic [DW-1:0] b_addr, b_wdata, b_rdata;
   logic          mem_we, busy, owner;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

   logic          a3_req, a3_we, a3_gnt, a3_done;
   logic [DW-1:0] a3_addr, a3_wdata, a3_rdata;
   logic          b3_req, b3_we, b3_gnt, b3_done;
   logic [DW-1:0] b3_addr, b3_wdata, b3_rdata;
   logic          mem3_we, busy3, owner3;
   logic [DW-1:0] mem3_addr, mem3_wdata, mem3_rdata;

   dmem_arbiter #(.DBITS(DW), .MEM_RD_LAT(1)) u1 (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   dmem_arbiter #(.DBITS(DW), .MEM_RD_LAT(3)) u3 (
      .clk(clk), .reset(reset),
      .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
      .a_gnt(a3_gnt), .a_done(a3_done), .a_rdata(a3_rdata),
      .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
      .b_gnt(b3_gnt), .b_done(b3_done), .b_rdata(b3_rdata),
      .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
      .mem_rdata(mem3_rdata), .busy(busy3), .owner(owner3)
   );

   int unsigned   n_cmp = 0;
   int unsigned   n_err = 0;
   logic [DW-1:0] exp_a[$];
   logic [DW-1:0] exp_b[$];
   logic [DW-1:0] model_a, model_b;
   logic [DW-1:0] mon_a_v, mon_b_v;

   // Memory content model: read data is a fixed function of the address.
   function automatic logic [DW-1:0] rd_fn(input logic [DW-1:0] addr);
      return addr ^ 32'hDEADBFEF;
   endfunction

   // Memory responder for u1: valid data only in the cycle it is due.
   int            rsp_cd = 0;
   bit            rsp_pend = 1'b0;
   logic [DW-1:0] rsp_data = '0;
   always @(negedge clk) begin
      if (rsp_cd > 0) rsp_cd = rsp_cd - 1;
      if (rsp_pend && rsp_cd == 0) begin
         mem_rdata = rsp_data;
         rsp_pend  = 1'b0;
      end else begin
         mem_rdata = 32'hBAD0BAD0;
      end
      if (a_gnt) begin
         rsp_cd = 2; rsp_data = rd_fn(a_addr); rsp_pend = 1'b1;
      end else if (b_gnt) begin
         rsp_cd = 2; rsp_data = rd_fn(b_addr); rsp_pend = 1'b1;
      end
   end

   // Scoreboard: every done pulse must match an outstanding transaction.
   always @(negedge clk) begin
      if (a_done) begin
         n_cmp++;
         if (exp_a.size() == 0) begin
            n_err++; $display("FAIL a_done_spurious: a_done=1 with nothing outstanding, a_rdata=%h", a_rdata);
         end else begin
            mon_a_v = exp_a.pop_front();
            if (a_rdata !== mon_a_v) begin
               n_err++; $display("FAIL a_done_rdata: got %h expected %h", a_rdata, mon_a_v);
            end
         end
      end
      if (b_done) begin
         n_cmp++;
         if (exp_b.size() == 0) begin
            n_err++; $display("FAIL b_done_spurious: b_done=1 with nothing outstanding, b_rdata=%h", b_rdata);
         end else begin
            mon_b_v = exp_b.pop_front();
            if (b_rdata !== mon_b_v) begin
               n_err++; $display("FAIL b_done_rdata: got %h expected %h", b_rdata, mon_b_v);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_req = 1'b0; b_req = 1'b0; a3_req = 1'b0;
      exp_a.delete(); exp_b.delete();
      model_a = '0; model_b = '0;
      next_cycle(); next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      next_cycle(); next_cycle();
      mid();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
      n_cmp++; if (a_done !== 1'b0 || b_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got a=%b b=%b expected 0 0", a_done, b_done); end
      n_cmp++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got a=%h b=%h expected 0 0", a_rdata, b_rdata); end
      n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL rst_owner: got %b expected 0", owner); end
      n_cmp++; if (busy3 !== 1'b0 || a3_rdata !== 32'h0) begin n_err++; $display("FAIL rst_u3: got busy=%b rdata=%h expected 0 0", busy3, a3_rdata); end
      next_cycle();
      reset = 1'b0;
      mid();
      n_cmp++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_err++; $display("FAIL idle_no_gnt: got a=%b b=%b expected 0 0", a_gnt, b_gnt); end
      next_cycle();
   endtask

   task automatic test_single_read();
      do_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_wdata = 32'h0;
      mid();
      n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_err++; $display("FAIL rd_gnt: got a=%b b=%b expected 1 0", a_gnt, b_gnt); end
      exp_a.push_back(32'hDEADBEEF); model_a = 32'hDEADBEEF;
      next_cycle(); a_req = 1'b0;
      mid();
      n_cmp++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin n_err++; $display("FAIL rd_issue: got addr=%h we=%b expected 100 0", mem_addr, mem_we); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_c1: got %b expected 1", busy); end
      next_cycle(); mid();
      n_cmp++; if (mem_addr !== 32'h100 || a_done !== 1'b0) begin n_err++; $display("FAIL rd_wait: got addr=%h done=%b expected 100 0", mem_addr, a_done); end
      next_cycle(); mid();
      n_cmp++; if (a_done !== 1'b1) begin n_err++; $display("FAIL rd_done_c3: got %b expected 1", a_done); end
      n_cmp++; if (a_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h expected deadbeef", a_rdata); end
      n_cmp++; if (b_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rd_c3_misc: got b_done=%b busy=%b expected 0 0", b_done, busy); end
      next_cycle();
   endtask

   task automatic test_alternate();
      logic ega, egb;
      do_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h200;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'h300;
      for (int c = 0; c <= 10; c++) begin
         mid();
         ega = (c == 0 || c == 6);
         egb = (c == 3 || c == 9);
         n_cmp++;
         if (a_gnt !== ega || b_gnt !== egb) begin
            n_err++; $display("FAIL alt_gnt_c%0d: got a=%b b=%b expected %b %b", c, a_gnt, b_gnt, ega, egb);
         end
         if (a_gnt) begin exp_a.push_back(rd_fn(a_addr)); model_a = rd_fn(a_addr); end
         if (b_gnt) begin exp_b.push_back(rd_fn(b_addr)); model_b = rd_fn(b_addr); end
         next_cycle();
         if (c == 9) begin a_req = 1'b0; b_req = 1'b0; end
      end
      next_cycle(); next_cycle();
   endtask

   task automatic test_write();
      b_req = 1'b1; b_we = 1'b1; b_addr = 32'hF0000004; b_wdata = 32'h3FF;
      mid();
      n_cmp++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin n_err++; $display("FAIL wr_gnt: got a=%b b=%b expected 0 1", a_gnt, b_gnt); end
      exp_b.push_back(model_b);
      next_cycle();
      b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0BAD0000; b_wdata = 32'h0;
      mid();
      n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we: got %b expected 1", mem_we); end
      n_cmp++; if (mem_addr !== 32'hF0000004) begin n_err++; $display("FAIL wr_mem_addr: got %h expected f0000004", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h3FF) begin n_err++; $display("FAIL wr_mem_wdata: got %h expected 3ff", mem_wdata); end
      n_cmp++; if (owner !== 1'b1 || b_done !== 1'b0) begin n_err++; $display("FAIL wr_issue: got owner=%b done=%b expected 1 0", owner, b_done); end
      next_cycle(); mid();
      n_cmp++; if (mem_we !== 1'b0 || b_done !== 1'b1) begin n_err++; $display("FAIL wr_done: got we=%b done=%b expected 0 1", mem_we, b_done); end
      n_cmp++; if (a_rdata !== model_a || b_rdata !== model_b) begin n_err++; $display("FAIL wr_rdata_kept: got a=%h b=%h expected %h %h", a_rdata, b_rdata, model_a, model_b); end
      next_cycle(); mid();
      n_cmp++; if (b_done !== 1'b0) begin n_err++; $display("FAIL wr_done_width: got %b expected 0", b_done); end
      next_cycle();
   endtask

   task automatic test_latency3();
      mem3_rdata = 32'hBAD0BAD0;
      a3_req = 1'b1; a3_we = 1'b0; a3_addr = 32'h40; a3_wdata = 32'h0;
      mid();
      n_cmp++; if (a3_gnt !== 1'b1) begin n_err++; $display("FAIL lat3_gnt: got %b expected 1", a3_gnt); end
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         if (c == 1) a3_req = 1'b0;
         mem3_rdata = (c == 4) ? 32'h12345678 : 32'hBAD0BAD0;
         mid();
         n_cmp++;
         if (busy3 !== (c <= 4) || a3_done !== (c == 5) || mem3_we !== 1'b0) begin
            n_err++; $display("FAIL lat3_c%0d: got busy=%b done=%b we=%b expected %b %b 0", c, busy3, a3_done, mem3_we, (c <= 4), (c == 5));
         end
         if (c <= 4) begin
            n_cmp++; if (mem3_addr !== 32'h40) begin n_err++; $display("FAIL lat3_addr_c%0d: got %h expected 40", c, mem3_addr); end
         end
      end
      n_cmp++; if (a3_rdata !== 32'h12345678) begin n_err++; $display("FAIL lat3_rdata: got %h expected 12345678", a3_rdata); end
      next_cycle();
      mem3_rdata = 32'hBAD0BAD0;
   endtask

   task automatic test_reset_mid();
      bit got_b;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h500;
      mid();
      n_cmp++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL rm_gnt: got %b expected 1", a_gnt); end
      exp_a.push_back(rd_fn(32'h500));
      next_cycle(); a_req = 1'b0;
      next_cycle();
      reset = 1'b1;
      exp_a.delete(); exp_b.delete(); model_a = '0; model_b = '0;
      mid();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_c2: got %b expected 1", busy); end
      next_cycle();
      reset = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h600;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'h700;
      mid();
      n_cmp++; if (busy !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rm_c3: got busy=%b we=%b expected 0 0", busy, mem_we); end
      n_cmp++; if (a_done !== 1'b0 || a_rdata !== 32'h0) begin n_err++; $display("FAIL rm_abandon: got done=%b rdata=%h expected 0 0", a_done, a_rdata); end
      n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_err++; $display("FAIL rm_ptr: got a=%b b=%b expected 1 0", a_gnt, b_gnt); end
      exp_a.push_back(rd_fn(32'h600)); model_a = rd_fn(32'h600);
      next_cycle(); a_req = 1'b0;
      got_b = 1'b0;
      for (int w = 1; w <= 10 && !got_b; w++) begin
         mid();
         if (b_gnt) begin
            got_b = 1'b1;
            n_cmp++; if (w != 3) begin n_err++; $display("FAIL rm_b_wait: got %0d cycles expected 3", w); end
            exp_b.push_back(rd_fn(b_addr)); model_b = rd_fn(b_addr);
         end
         next_cycle();
      end
      b_req = 1'b0;
      n_cmp++; if (!got_b) begin n_err++; $display("FAIL rm_b_lost: got no b_gnt expected one within 10 cycles"); end
      next_cycle(); next_cycle(); next_cycle();
   endtask

   task automatic test_back_to_back();
      a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h55;
      mid();
      n_cmp++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_wr_gnt: got %b expected 1", a_gnt); end
      exp_a.push_back(model_a);
      next_cycle();
      a_we = 1'b0; a_addr = 32'h20; a_wdata = 32'h0;
      mid();
      n_cmp++; if (a_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h10) begin n_err++; $display("FAIL b2b_issue: got gnt=%b we=%b addr=%h expected 0 1 10", a_gnt, mem_we, mem_addr); end
      next_cycle(); mid();
      n_cmp++; if (a_done !== 1'b1 || a_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_overlap: got done=%b gnt=%b expected 1 1", a_done, a_gnt); end
      exp_a.push_back(rd_fn(32'h20)); model_a = rd_fn(32'h20);
      next_cycle();
      a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 32'h900;
      mid();
      n_cmp++; if (busy !== 1'b1 || mem_addr !== 32'h20 || b_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_rd: got busy=%b addr=%h bgnt=%b expected 1 20 0", busy, mem_addr, b_gnt); end
      next_cycle(); b_req = 1'b0;
      mid();
      n_cmp++; if (b_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_drop_gnt: got %b expected 0", b_gnt); end
      next_cycle(); mid();
      n_cmp++; if (a_done !== 1'b1 || a_rdata !== rd_fn(32'h20)) begin n_err++; $display("FAIL b2b_rd_done: got done=%b rdata=%h expected 1 %h", a_done, a_rdata, rd_fn(32'h20)); end
      for (int i = 0; i < 4; i++) next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the bench completed");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      a3_req = 1'b0; a3_we = 1'b0; a3_addr = '0; a3_wdata = '0;
      b3_req = 1'b0; b3_we = 1'b0; b3_addr = '0; b3_wdata = '0;
      mem3_rdata = 32'hBAD0BAD0;
      model_a = '0; model_b = '0;

      test_reset();
      test_single_read();
      test_alternate();
      test_write();
      test_latency3();
      test_reset_mid();
      test_back_to_back();

      n_cmp++; if (exp_a.size() != 0 || exp_b.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d/%0d outstanding expected 0/0", exp_a.size(), exp_b.size()); end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the data-memory / memory-mapped I/O port: KEY, SW, HEX, LEDR and LEDG behind 0xF00000xx.
- Port A is the CPU load/store path. Port B is a secondary master, such as a debug loader or DMA.
- Grants one transaction at a time with round-robin fairness, and registers the request.
- Drives the memory for one issue cycle, waits a programmable read latency, and returns data with a done pulse.

Parameters:
- DBITS, 32, data and address width.
- MEM_RD_LAT, 1, cycles from address issue to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; hold until a_gnt.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  DBITS  port A byte address.
- a_wdata  in  DBITS  port A write data.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_done  out  1  port A transaction complete (one-cycle pulse).
- a_rdata  out  DBITS  port A read data, valid when a_done and the transaction was a read.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as the A ports, for port B.
- mem_we  out  1  memory write strobe.
- mem_addr  out  DBITS  memory address, passed unmodified; I/O decode is downstream.
- mem_wdata  out  DBITS  memory write data.
- mem_rdata  in  DBITS  memory read data.
- busy  out  1  state != IDLE.
- owner  out  1  port of the current or last transaction (0 = A, 1 = B).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- States: IDLE, ISSUE, RWAIT.
- Reset values: state IDLE; mem_we 0; mem_addr 0; mem_wdata 0; a_done and b_done 0; a_rdata and b_rdata 0; owner 0; busy 0; round-robin pointer last = B, so A wins the first tie.

IDLE:
- If only one port requests, that port is selected.
- If both request, the port not equal to last is selected.
- The selected port's gnt is asserted combinationally in the same cycle.
- On the clock edge: latch we, addr and wdata; set owner and last to the selected port; go to ISSUE.
- No request: stay in IDLE; no gnt.

ISSUE (cycle T):
- mem_addr and mem_wdata come from the latched registers.
- mem_we = latched we.
- Write: go to IDLE. The owner's done is asserted in T+1.
- Read: go to RWAIT and load the latency counter with MEM_RD_LAT.

RWAIT:
- mem_addr held; mem_we 0.
- The counter decrements each cycle.
- In cycle T+MEM_RD_LAT, mem_rdata is captured into the owner's rdata register.
- Go to IDLE; the owner's done is asserted in T+MEM_RD_LAT+1.

Outputs and pacing:
- done is registered and high for exactly one cycle, only for the owner port.
- rdata holds its value until that port's next read completes. Writes do not change rdata.
- mem_we is high only in ISSUE of a write, for exactly one cycle.
- IDLE can accept a new request in the same cycle that done is visible, giving back-to-back operation.
- Best-case transaction interval: 2 cycles for a write, MEM_RD_LAT+2 cycles for a read.

Boundary conditions:
- A req dropped before gnt is ignored.
- Changes to req, addr or data after gnt have no effect on the latched transaction.
- With req held continuously by both ports, grants strictly alternate.
- gnt is never asserted outside IDLE. A requester waits and is not lost.
- Reset in any state: next cycle state is IDLE and mem_we is 0. The in-flight transaction is abandoned with no done, and the pointer is restored to B.

Test Plan:
1. Reset, then A reads 0x100 (MEM_RD_LAT=1), with mem_rdata=0xDEADBEEF at cycle 2 -> a_gnt at cycle 0; mem_addr=0x100 in cycles 1-2; a_done=1 and a_rdata=0xDEADBEEF at cycle 3; b_done stays 0.
2. A and B both request at cycle 0 after reset, and both hold req (reads) -> grant order is A, B, A, B; grants at cycles 0, 3, 6, 9.
3. B writes 0x3FF to 0xF0000004 -> mem_we=1 for exactly one cycle with mem_addr=0xF0000004 and mem_wdata=0x3FF; b_done one cycle later; a_rdata and b_rdata unchanged.
4. MEM_RD_LAT=3, A reads 0x40 -> mem_rdata sampled at cycle 4; a_done at cycle 5; busy high in cycles 1-4.
5. Reset asserted at cycle 2 of a read -> at cycle 3 state is IDLE, busy=0, mem_we=0, and no done ever appears. The next simultaneous A/B request grants A.
6. A write followed immediately by a held A read -> write done and read a_gnt occur in the same cycle, and there are no idle gaps between the two transactions.
